div_ctrl: RTL

//  Sequencer between the EXE stage and sdiv_N_by_N for RV32M DIV/DIVU/REM/REMU. Accepts one op
//  per valid/ready handshake and registers the operands. Drives/holds the divider start

---
 rtl/div_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EXE stage and an iterative N-by-N divider.
// Handles DIV/DIVU/REM/REMU, resolves divide-by-zero and signed overflow locally,
// and keeps a one-entry cache of the last divider result so a DIV/REM pair on the
// same operands only runs the divider once.
module div_ctrl #(
  parameter int N      = 32,
  parameter int TAG_W  = 4,
  parameter int USE_RC = 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [N-1:0]     req_dividend,
  input  logic [N-1:0]     req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_div0,
  output logic             rsp_ovf,
  output logic             div_start,
  output logic             div_is_signed,
  output logic [N-1:0]     div_dividend,
  output logic [N-1:0]     div_divisor,
  input  logic             div_done,
  input  logic [N-1:0]     div_quotient,
  input  logic [N-1:0]     div_remainder
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

  state_t state;
  state_t state_next;

  logic         accept;
  logic         req_signed;
  logic         is_div0;
  logic         is_ovf;
  logic         cache_hit;
  logic         div_busy;
  logic         rem_q;

  logic         cache_valid;
  logic [N-1:0] cache_dividend;
  logic [N-1:0] cache_divisor;
  logic         cache_signed;
  logic [N-1:0] cache_q;
  logic [N-1:0] cache_r;

  // Request classification, next-state selection and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE) && !flush;
    rsp_valid  = (state == RESP);
    div_busy   = (state == RUN) || (state == DRAIN);
    div_start  = div_busy;
    accept     = req_valid && req_ready;
    req_signed = ~req_op[0];
    is_div0    = (req_divisor == '0);
    is_ovf     = req_signed && (req_dividend == MIN_NEG) && (req_divisor == '1);
    cache_hit  = (USE_RC != 0) && cache_valid &&
                 (cache_dividend == req_dividend) &&
                 (cache_divisor == req_divisor) &&
                 (cache_signed == req_signed);
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_div0 || is_ovf || cache_hit) state_next = RESP;
          else                                state_next = RUN;
        end
      end
      RUN: begin
        if (flush) state_next = div_done ? IDLE : DRAIN;
        else if (div_done) state_next = RESP;
      end
      DRAIN: begin
        if (div_done) state_next = IDLE;
      end
      RESP: begin
        if (flush || rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // Operand capture for the divider and the held response fields
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rem_q         <= 1'b0;
      rsp_data      <= '0;
      rsp_tag       <= '0;
      rsp_div0      <= 1'b0;
      rsp_ovf       <= 1'b0;
      div_is_signed <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else if (accept) begin
      rem_q    <= req_op[1];
      rsp_tag  <= req_tag;
      rsp_div0 <= is_div0;
      rsp_ovf  <= is_ovf;
      if (is_div0) begin
        rsp_data <= req_op[1] ? req_dividend : '1;
      end else if (is_ovf) begin
        rsp_data <= req_op[1] ? '0 : req_dividend;
      end else if (cache_hit) begin
        rsp_data <= req_op[1] ? cache_r : cache_q;
      end else begin
        div_is_signed <= req_signed;
        div_dividend  <= req_dividend;
        div_divisor   <= req_divisor;
      end
    end else if (div_busy && div_done) begin
      rsp_data <= rem_q ? div_remainder : div_quotient;
    end
  end

  // One-entry result cache, refilled by every divider completion (including drained ones)
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cache_valid    <= 1'b0;
      cache_dividend <= '0;
      cache_divisor  <= '0;
      cache_signed   <= 1'b0;
      cache_q        <= '0;
      cache_r        <= '0;
    end else if (div_busy && div_done) begin
      cache_valid    <= (USE_RC != 0);
      cache_dividend <= div_dividend;
      cache_divisor  <= div_divisor;
      cache_signed   <= div_is_signed;
      cache_q        <= div_quotient;
      cache_r        <= div_remainder;
    end
  end

endmodule
